// File: rtl/rp_stream_trailer_echo.sv
// Stream echo responder: buffers inbound beats in a FIFO, replays them unchanged,
// and closes every packet with a trailer beat (checksum, marker, sequence, beat count).
module rp_stream_trailer_echo #(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk100mhz_0,
  input  logic              peripheral_reset_0,
  input  logic [DATA_W-1:0] AXI_STR_TXD_0_tdata,
  input  logic              AXI_STR_TXD_0_tlast,
  input  logic              AXI_STR_TXD_0_tvalid,
  output logic              AXI_STR_TXD_0_tready,
  output logic [DATA_W-1:0] AXI_STR_RXD_0_tdata,
  output logic              AXI_STR_RXD_0_tlast,
  output logic              AXI_STR_RXD_0_tvalid,
  input  logic              AXI_STR_RXD_0_tready,
  output logic [31:0]       pkt_count
);

  // Handshakes on both streams: a beat transfers on a rising edge where tvalid && tready;
  // once tvalid is raised, tdata/tlast hold until that transfer happens.

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_DATA, S_TRAIL} state_t;

  state_t            state, state_nxt;
  logic [DATA_W:0]   mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              fifo_empty, fifo_full;
  logic [DATA_W-1:0] head_data;
  logic              head_last;
  logic              push, pop, trail_done;
  logic [31:0]       seq;
  logic [CNT_W-1:0]  beat_cnt;
  logic [DATA_W-65:0] csum;
  logic [15:0]       cnt16;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_data  = mem[rd_ptr[AW-1:0]][DATA_W-1:0];
  assign head_last  = mem[rd_ptr[AW-1:0]][DATA_W];
  assign cnt16      = 16'(beat_cnt);

  assign AXI_STR_TXD_0_tready = !fifo_full && !peripheral_reset_0;
  assign push       = AXI_STR_TXD_0_tvalid && AXI_STR_TXD_0_tready;
  assign pop        = (state == S_DATA) && AXI_STR_RXD_0_tvalid && AXI_STR_RXD_0_tready;
  assign trail_done = (state == S_TRAIL) && AXI_STR_RXD_0_tvalid && AXI_STR_RXD_0_tready;
  assign pkt_count  = seq;

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk100mhz_0) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {AXI_STR_TXD_0_tlast, AXI_STR_TXD_0_tdata};
  end

  always_ff @(posedge clk100mhz_0) begin
    if (peripheral_reset_0) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      seq      <= '0;
      beat_cnt <= '0;
      csum     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
        csum   <= csum ^ head_data[DATA_W-1:64];
        if (beat_cnt != '1) beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (trail_done) begin
        seq      <= seq + 32'd1;
        beat_cnt <= '0;
        csum     <= '0;
      end
    end
  end

  always_ff @(posedge clk100mhz_0) begin
    if (peripheral_reset_0) state <= S_DATA;
    else                    state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_DATA:  if (pop && head_last) state_nxt = S_TRAIL;
      S_TRAIL: if (trail_done)       state_nxt = S_DATA;
      default: state_nxt = S_DATA;
    endcase
  end

  // Outputs are forced idle while reset is asserted so the reset cycle itself is quiet.
  always_comb begin
    AXI_STR_RXD_0_tvalid = 1'b0;
    AXI_STR_RXD_0_tlast  = 1'b0;
    AXI_STR_RXD_0_tdata  = '0;
    if (!peripheral_reset_0) begin
      case (state)
        S_DATA: begin
          AXI_STR_RXD_0_tvalid = !fifo_empty;
          AXI_STR_RXD_0_tdata  = head_data;
        end
        S_TRAIL: begin
          AXI_STR_RXD_0_tvalid = 1'b1;
          AXI_STR_RXD_0_tlast  = 1'b1;
          AXI_STR_RXD_0_tdata  = {csum, 16'hA5C3, seq, cnt16};
        end
        default: ;
      endcase
    end
  end

endmodule
